// File: rtl/uart_fifo_ctrl_if.sv
// Byte-stream side of uart_fifo_ctrl: TX push and RX pop valid/ready handshakes.
// The controller uses the slave modport; the producer/consumer uses master.
interface uart_fifo_ctrl_if #(
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [BIT_WIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Buffered UART: TX/RX FIFOs, internal bit timing, configurable frame format.
// Define UART_LOOPBACK_EN to add the i_loopback port (RX taps the TX line, pin held idle).
//
// state   | meaning
// S_IDLE  | line idle, waiting for FIFO data (TX) or a start edge (RX)
// S_START | start bit (RX: counting to mid-bit, then glitch check)
// S_DATA  | data bits, r_*_bit counts down remaining bits
// S_PAR   | parity bit (never entered when PARITY == 0)
// S_STOP  | stop bit(s); RX samples only the first
module uart_fifo_ctrl #(
  parameter int BIT_WIDTH    = 8,
  parameter int START_BIT    = 0,
  parameter int LSB_TO_MSB   = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_fifo_ctrl_if.slave   bus,
  output logic              o_tx_pin,
  input  logic              i_rx_pin,
  output logic              o_busy,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic              o_overrun
`ifdef UART_LOOPBACK_EN
  ,
  input  logic              i_loopback
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BCW = $clog2(BIT_WIDTH);

  localparam logic [CW-1:0]  C_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  C_STOP = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] C_LAST = BCW'(BIT_WIDTH - 1);

  localparam logic L_START   = (START_BIT != 0);
  localparam logic L_IDLE    = (START_BIT == 0);
  localparam logic L_LSB     = (LSB_TO_MSB != 0);
  localparam logic L_HAS_PAR = (PARITY != 0);
  localparam logic L_ODD     = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // ---------------- TX FIFO ----------------
  logic [BIT_WIDTH-1:0] r_txf_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_txf_wr, r_txf_rd;
  logic                 w_txf_empty, w_txf_full, w_txf_push, w_txf_pop;
  logic [BIT_WIDTH-1:0] w_txf_head;

  assign w_txf_empty  = (r_txf_wr == r_txf_rd);
  assign w_txf_full   = (r_txf_wr[AW-1:0] == r_txf_rd[AW-1:0]) &&
                        (r_txf_wr[PW-1] != r_txf_rd[PW-1]);
  assign w_txf_push   = bus.tx_valid && !w_txf_full;
  assign w_txf_head   = r_txf_mem[r_txf_rd[AW-1:0]];
  assign bus.tx_ready = !w_txf_full;

  always_ff @(posedge clk) begin
    if (w_txf_push) r_txf_mem[r_txf_wr[AW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txf_wr <= '0;
      r_txf_rd <= '0;
    end else begin
      if (w_txf_push) r_txf_wr <= r_txf_wr + PW'(1);
      if (w_txf_pop)  r_txf_rd <= r_txf_rd + PW'(1);
    end
  end

  // ---------------- TX FSM ----------------
  state_t               r_tx_state, w_tx_state_nx;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nx;
  logic [BCW-1:0]       r_tx_bit, w_tx_bit_nx;
  logic [BIT_WIDTH-1:0] r_tx_shift, w_tx_shift_nx;
  logic                 r_tx_par, w_tx_par_nx;
  logic                 w_tx_line, w_tx_load;
  logic                 r_tx_pin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_pin   <= L_IDLE;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_par   <= w_tx_par_nx;
      r_tx_pin   <= w_tx_line;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_par_nx   = r_tx_par;
    w_tx_line     = L_IDLE;
    w_tx_load     = 1'b0;
    case (r_tx_state)
      S_IDLE: w_tx_load = !w_txf_empty;
      S_START: begin
        w_tx_line = L_START;
        if (r_tx_cnt == '0) begin
          w_tx_state_nx = S_DATA;
          w_tx_cnt_nx   = C_BIT;
          w_tx_bit_nx   = C_LAST;
        end else begin
          w_tx_cnt_nx = r_tx_cnt - CW'(1);
        end
      end
      S_DATA: begin
        w_tx_line = L_LSB ? r_tx_shift[0] : r_tx_shift[BIT_WIDTH-1];
        if (r_tx_cnt == '0) begin
          w_tx_shift_nx = L_LSB ? (r_tx_shift >> 1) : (r_tx_shift << 1);
          if (r_tx_bit == '0) begin
            w_tx_state_nx = L_HAS_PAR ? S_PAR : S_STOP;
            w_tx_cnt_nx   = L_HAS_PAR ? C_BIT : C_STOP;
          end else begin
            w_tx_bit_nx = r_tx_bit - BCW'(1);
            w_tx_cnt_nx = C_BIT;
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt - CW'(1);
        end
      end
      S_PAR: begin
        w_tx_line = r_tx_par;
        if (r_tx_cnt == '0) begin
          w_tx_state_nx = S_STOP;
          w_tx_cnt_nx   = C_STOP;
        end else begin
          w_tx_cnt_nx = r_tx_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (r_tx_cnt == '0) begin
          // Chain straight into the next start bit when more data waits.
          if (!w_txf_empty) w_tx_load = 1'b1;
          else              w_tx_state_nx = S_IDLE;
        end else begin
          w_tx_cnt_nx = r_tx_cnt - CW'(1);
        end
      end
      default: w_tx_state_nx = S_IDLE;
    endcase
    if (w_tx_load) begin
      w_tx_state_nx = S_START;
      w_tx_cnt_nx   = C_BIT;
      w_tx_shift_nx = w_txf_head;
      w_tx_par_nx   = (^w_txf_head) ^ L_ODD;
    end
  end

  assign w_txf_pop = w_tx_load;

  // ---------------- RX line select ----------------
  logic r_rx_s1, r_rx_s2, r_rx_prev, w_rx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= L_IDLE;
      r_rx_s2   <= L_IDLE;
      r_rx_prev <= L_IDLE;
    end else begin
      r_rx_s1   <= i_rx_pin;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= w_rx_line;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign w_rx_line = i_loopback ? r_tx_pin : r_rx_s2;
  assign o_tx_pin  = i_loopback ? L_IDLE : r_tx_pin;
`else
  assign w_rx_line = r_rx_s2;
  assign o_tx_pin  = r_tx_pin;
`endif

  // ---------------- RX FIFO ----------------
  logic [BIT_WIDTH-1:0] r_rxf_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_rxf_wr, r_rxf_rd;
  logic                 w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop;
  logic [BIT_WIDTH-1:0] r_rx_shift, w_rx_shift_nx;

  assign w_rxf_empty  = (r_rxf_wr == r_rxf_rd);
  assign w_rxf_full   = (r_rxf_wr[AW-1:0] == r_rxf_rd[AW-1:0]) &&
                        (r_rxf_wr[PW-1] != r_rxf_rd[PW-1]);
  assign w_rxf_pop    = !w_rxf_empty && bus.rx_ready;
  assign bus.rx_valid = !w_rxf_empty;
  assign bus.rx_data  = w_rxf_empty ? '0 : r_rxf_mem[r_rxf_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_rxf_push) r_rxf_mem[r_rxf_wr[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxf_wr <= '0;
      r_rxf_rd <= '0;
    end else begin
      if (w_rxf_push) r_rxf_wr <= r_rxf_wr + PW'(1);
      if (w_rxf_pop)  r_rxf_rd <= r_rxf_rd + PW'(1);
    end
  end

  // ---------------- RX FSM ----------------
  state_t         r_rx_state, w_rx_state_nx;
  logic [CW-1:0]  r_rx_cnt, w_rx_cnt_nx;
  logic [BCW-1:0] r_rx_bit, w_rx_bit_nx;
  logic           r_rx_par, w_rx_par_nx;
  logic           r_rx_bad_par, w_rx_bad_par_nx;
  logic           w_ferr, w_perr, w_ovr;
  logic           r_frame_err, r_parity_err, r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par     <= 1'b0;
      r_rx_bad_par <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nx;
      r_rx_cnt     <= w_rx_cnt_nx;
      r_rx_bit     <= w_rx_bit_nx;
      r_rx_shift   <= w_rx_shift_nx;
      r_rx_par     <= w_rx_par_nx;
      r_rx_bad_par <= w_rx_bad_par_nx;
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
      r_overrun    <= w_ovr;
    end
  end

  always_comb begin
    w_rx_state_nx   = r_rx_state;
    w_rx_cnt_nx     = r_rx_cnt;
    w_rx_bit_nx     = r_rx_bit;
    w_rx_shift_nx   = r_rx_shift;
    w_rx_par_nx     = r_rx_par;
    w_rx_bad_par_nx = r_rx_bad_par;
    w_rxf_push      = 1'b0;
    w_ferr          = 1'b0;
    w_perr          = 1'b0;
    w_ovr           = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (r_rx_prev == L_IDLE && w_rx_line == L_START) begin
          w_rx_state_nx = S_START;
          w_rx_cnt_nx   = C_HALF;
        end
      end
      S_START: begin
        if (r_rx_cnt == '0) begin
          if (w_rx_line == L_IDLE) begin
            w_rx_state_nx = S_IDLE;
          end else begin
            w_rx_state_nx   = S_DATA;
            w_rx_cnt_nx     = C_BIT;
            w_rx_bit_nx     = C_LAST;
            w_rx_par_nx     = 1'b0;
            w_rx_bad_par_nx = 1'b0;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_rx_cnt == '0) begin
          w_rx_shift_nx = L_LSB ? {w_rx_line, r_rx_shift[BIT_WIDTH-1:1]}
                                : {r_rx_shift[BIT_WIDTH-2:0], w_rx_line};
          w_rx_par_nx   = r_rx_par ^ w_rx_line;
          w_rx_cnt_nx   = C_BIT;
          if (r_rx_bit == '0) w_rx_state_nx = L_HAS_PAR ? S_PAR : S_STOP;
          else                w_rx_bit_nx   = r_rx_bit - BCW'(1);
        end else begin
          w_rx_cnt_nx = r_rx_cnt - CW'(1);
        end
      end
      S_PAR: begin
        if (r_rx_cnt == '0) begin
          w_rx_bad_par_nx = (w_rx_line != (r_rx_par ^ L_ODD));
          w_rx_state_nx   = S_STOP;
          w_rx_cnt_nx     = C_BIT;
        end else begin
          w_rx_cnt_nx = r_rx_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (r_rx_cnt == '0) begin
          // A pop in the same cycle frees a slot, so a full FIFO still accepts.
          w_rx_state_nx = S_IDLE;
          w_ferr        = (w_rx_line != L_IDLE);
          w_perr        = r_rx_bad_par;
          if (!w_ferr && !w_perr) begin
            if (w_rxf_full && !w_rxf_pop) w_ovr      = 1'b1;
            else                          w_rxf_push = 1'b1;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt - CW'(1);
        end
      end
      default: w_rx_state_nx = S_IDLE;
    endcase
  end

  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_tx_state != S_IDLE) || (r_rx_state != S_IDLE) || !w_txf_empty;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: DUT A (8N1, LSB first, depth 4) exercises TX,
// DUT B (8E2, MSB first, depth 8) exercises RX; both at 4 clocks per bit.
module tb_uart_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  uart_fifo_ctrl_if #(.BIT_WIDTH(8)) ifa ();
  uart_fifo_ctrl_if #(.BIT_WIDTH(8)) ifb ();

  logic a_txp, a_rxp, a_busy, a_ferr, a_perr, a_ovr;
  logic b_txp, b_rxp, b_busy, b_ferr, b_perr, b_ovr;
  logic lb = 1'b0;

  uart_fifo_ctrl #(
    .BIT_WIDTH(8), .START_BIT(0), .LSB_TO_MSB(1), .CLKS_PER_BIT(4),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .o_tx_pin(a_txp), .i_rx_pin(a_rxp), .o_busy(a_busy),
    .o_frame_err(a_ferr), .o_parity_err(a_perr), .o_overrun(a_ovr)
`ifdef UART_LOOPBACK_EN
    , .i_loopback(lb)
`endif
  );

  uart_fifo_ctrl #(
    .BIT_WIDTH(8), .START_BIT(0), .LSB_TO_MSB(0), .CLKS_PER_BIT(4),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .o_tx_pin(b_txp), .i_rx_pin(b_rxp), .o_busy(b_busy),
    .o_frame_err(b_ferr), .o_parity_err(b_perr), .o_overrun(b_ovr)
`ifdef UART_LOOPBACK_EN
    , .i_loopback(lb)
`endif
  );

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] aq[$];
  int         startq[$];
  bit         tx_mon_en = 1'b1;
  int         b_ferr_n = 0, b_perr_n = 0, b_ovr_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decodes A's serial output (8N1, LSB first, mid-bit sampling) against txq.
  initial begin
    logic prev;
    logic [7:0] d;
    logic stp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n && prev && !a_txp) begin
        startq.push_back(cyc);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          d[k] = a_txp;
        end
        repeat (4) @(negedge clk);
        stp = a_txp;
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_frame: got unexpected frame 0x%0h expected none", d);
        end else begin
          check("tx_frame", d, txq.pop_front());
        end
        check("tx_stop", stp, 1'b1);
        prev = stp;
      end else begin
        prev = a_txp;
      end
    end
  end

  // Pops the RX scoreboards on every handshake and counts B's error pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifb.rx_valid && ifb.rx_ready) begin
          if (rxq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_data_b: got unexpected 0x%0h expected none", ifb.rx_data);
          end else begin
            check("rx_data_b", ifb.rx_data, rxq.pop_front());
          end
        end
        if (ifa.rx_valid && ifa.rx_ready) begin
          if (aq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_data_a: got unexpected 0x%0h expected none", ifa.rx_data);
          end else begin
            check("rx_data_a", ifa.rx_data, aq.pop_front());
          end
        end
        if (b_ferr) b_ferr_n++;
        if (b_perr) b_perr_n++;
        if (b_ovr)  b_ovr_n++;
      end
    end
  end

  // Drives one 8E2 MSB-first frame into B; caller stands at posedge+2.
  task automatic send_b(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                        input logic expect_it);
    logic [11:0] fr;
    fr[0] = 1'b0;
    for (int k = 0; k < 8; k++) fr[1+k] = d[7-k];
    fr[9]  = (^d) ^ bad_par;
    fr[10] = !bad_stop;
    fr[11] = 1'b1;
    if (expect_it && !bad_par && !bad_stop) rxq.push_back(d);
    for (int i = 0; i < 12; i++) begin
      b_rxp = fr[i];
      repeat (4) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  fr1;
    logic [39:0] exp40, cap40;
    int          acc, first_block, guard, bad_gaps;
    logic        saw_low;

    ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx_ready = 1'b0;
    ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.rx_ready = 1'b0;
    a_rxp = 1'b1; b_rxp = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tx_pin", a_txp, 1'b1);
    check("rst_tx_ready", ifa.tx_ready, 1'b1);
    check("rst_rx_valid", ifb.rx_valid, 1'b0);
    check("rst_rx_data", ifb.rx_data, 8'h00);
    check("rst_busy", a_busy, 1'b0);
    check("rst_err_pulses", {b_ferr, b_perr, b_ovr}, 3'b000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #2;

    // Single TX frame 0xA5 with exact bit durations and 2-cycle latency
    fr1 = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 40; j++) exp40[j] = fr1[j/4];
    ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
    txq.push_back(8'hA5);
    @(posedge clk); #2;
    ifa.tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tx_latency_pre", a_txp, 1'b1);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      cap40[j] = a_txp;
    end
    check("tx_a5_waveform", cap40, exp40);
    @(negedge clk);
    check("tx_idle_after", a_txp, 1'b1);
    repeat (6) @(posedge clk); #2;

    // Back-to-back TX with backpressure, depth 4
    startq.delete();
    acc = 0; first_block = -1; guard = 0;
    ifa.tx_data = 8'h01; ifa.tx_valid = 1'b1;
    while (acc < 6 && guard < 2000) begin
      guard++;
      @(negedge clk);
      if (ifa.tx_ready) begin
        txq.push_back(8'(acc + 1));
        acc++;
        @(posedge clk); #2;
        ifa.tx_data = 8'(acc + 1);
      end else begin
        if (first_block < 0) first_block = acc;
        @(posedge clk); #2;
      end
    end
    ifa.tx_valid = 1'b0;
    check("tx_accepts", acc, 6);
    check("tx_ready_drop_after", first_block, 5);
    for (int g = 0; g < 400 && txq.size() != 0; g++) @(negedge clk);
    check("tx_all_sent", txq.size(), 0);
    check("tx_frame_count", startq.size(), 6);
    bad_gaps = 0;
    for (int i = 1; i < startq.size(); i++)
      if (startq[i] - startq[i-1] != 40) bad_gaps++;
    check("tx_no_gap", bad_gaps, 0);
    repeat (10) @(posedge clk); #2;

    // RX 0x3C as 8E2 MSB first
    send_b(8'h3C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rx_valid_good", ifb.rx_valid, 1'b1);
    check("rx_data_good", ifb.rx_data, 8'h3C);
    @(posedge clk); #2;
    ifb.rx_ready = 1'b1;
    @(posedge clk); #2;
    ifb.rx_ready = 1'b0;
    @(negedge clk);
    check("rx_popped", ifb.rx_valid, 1'b0);
    check("rx_q_empty_good", rxq.size(), 0);
    @(posedge clk); #2;

    // Corrupted parity
    send_b(8'h3C, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("rx_parity_err_count", b_perr_n, 1);
    check("rx_parity_dropped", ifb.rx_valid, 1'b0);
    @(posedge clk); #2;

    // One-cycle start glitch
    b_rxp = 1'b0;
    @(posedge clk); #2;
    b_rxp = 1'b1;
    repeat (20) @(posedge clk); #2;
    @(negedge clk);
    check("rx_glitch_no_data", ifb.rx_valid, 1'b0);
    check("rx_glitch_no_err", {b_ferr_n, b_perr_n, b_ovr_n}, {32'd0, 32'd1, 32'd0});
    check("rx_glitch_idle", b_busy, 1'b0);
    @(posedge clk); #2;

    // Bad stop bit
    send_b(8'h81, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("rx_frame_err_count", b_ferr_n, 1);
    check("rx_frame_dropped", ifb.rx_valid, 1'b0);
    check("rx_frame_no_perr", b_perr_n, 1);
    @(posedge clk); #2;

    // Overrun: 9 frames into depth 8 with no consumer
    for (int i = 0; i < 9; i++) begin
      send_b(8'(8'h11 + i), 1'b0, 1'b0, i < 8);
      if (i == 7) check("rx_no_overrun_at_8", b_ovr_n, 0);
    end
    @(negedge clk);
    check("rx_overrun_count", b_ovr_n, 1);
    @(posedge clk); #2;
    ifb.rx_ready = 1'b1;
    repeat (10) @(posedge clk); #2;
    ifb.rx_ready = 1'b0;
    check("rx_overrun_drained", rxq.size(), 0);
    check("rx_overrun_empty", ifb.rx_valid, 1'b0);

    // Reset mid TX DATA with data pending in both FIFOs
    send_b(8'h77, 1'b0, 1'b0, 1'b0);
    tx_mon_en = 1'b0;
    ifa.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifa.tx_data = 8'h00;
      @(posedge clk); #2;
    end
    ifa.tx_valid = 1'b0;
    repeat (12) @(posedge clk); #2;
    check("rst_pre_mid_data", a_txp, 1'b0);
    check("rst_pre_rx_valid", ifb.rx_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_pin", a_txp, 1'b1);
    check("rst_mid_tx_ready", ifa.tx_ready, 1'b1);
    check("rst_mid_busy", a_busy, 1'b0);
    check("rst_mid_rx_valid", ifb.rx_valid, 1'b0);
    check("rst_mid_rx_data", ifb.rx_data, 8'h00);
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!a_txp) saw_low = 1'b1;
    end
    check("rst_tx_fifo_empty", saw_low, 1'b0);
    tx_mon_en = 1'b1;

`ifdef UART_LOOPBACK_EN
    // Loopback round trip on both bit orders; pins stay idle
    @(posedge clk); #2;
    lb = 1'b1;
    ifa.rx_ready = 1'b1; ifb.rx_ready = 1'b1;
    aq.push_back(8'h5A); rxq.push_back(8'h5A);
    ifa.tx_data = 8'h5A; ifa.tx_valid = 1'b1;
    ifb.tx_data = 8'h5A; ifb.tx_valid = 1'b1;
    @(posedge clk); #2;
    ifa.tx_valid = 1'b0; ifb.tx_valid = 1'b0;
    saw_low = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (!a_txp || !b_txp) saw_low = 1'b1;
    end
    check("lb_pins_idle", saw_low, 1'b0);
    check("lb_lsb_rx", aq.size(), 0);
    check("lb_msb_rx", rxq.size(), 0);
    lb = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
